// File: rtl/gray_ptr_fifo_ctrl.sv
// rtl/gray_ptr_fifo_ctrl.sv - single-clock FIFO with registered Gray read/write pointers
// Full/empty come from the Gray pointers so the same compare works once the FIFO is split across clocks.
module gray_ptr_fifo_ctrl #(
  parameter int N      = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [N-1:0]      in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [N-1:0]      out_data_o,
  output logic [ADDR_W:0]   wptr_gray_o,
  output logic [ADDR_W:0]   rptr_gray_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [N-1:0]    mem [DEPTH];
  logic [ADDR_W:0] wbin, rbin, wbin_nxt, rbin_nxt;
  logic [ADDR_W:0] wgray, rgray, level_q;
  logic [ADDR_W:0] full_cmp;
  logic            full, empty, push, pop;

  // Full: write pointer has lapped read pointer once, i.e. top two Gray bits inverted.
  generate
    if (ADDR_W == 1) begin : g_full_w1
      assign full_cmp = ~rgray;
    end else begin : g_full_wn
      assign full_cmp = {~rgray[ADDR_W:ADDR_W-1], rgray[ADDR_W-2:0]};
    end
  endgenerate

  assign empty = (wgray == rgray);
  assign full  = (wgray == full_cmp);

  assign in_ready_o  = ~full;
  assign out_valid_o = ~empty;
  assign push        = in_valid_i & ~full;
  assign pop         = out_ready_i & ~empty;

  always_comb begin
    wbin_nxt = wbin + {{ADDR_W{1'b0}}, push};
    rbin_nxt = rbin + {{ADDR_W{1'b0}}, pop};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      wbin    <= '0;
      rbin    <= '0;
      wgray   <= '0;
      rgray   <= '0;
      level_q <= '0;
    end else begin
      wbin    <= wbin_nxt;
      rbin    <= rbin_nxt;
      wgray   <= wbin_nxt ^ (wbin_nxt >> 1);
      rgray   <= rbin_nxt ^ (rbin_nxt >> 1);
      level_q <= wbin_nxt - rbin_nxt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !flush_i && push) begin
      mem[wbin[ADDR_W-1:0]] <= in_data_i;
    end
  end

  assign out_data_o  = mem[rbin[ADDR_W-1:0]];
  assign wptr_gray_o = wgray;
  assign rptr_gray_o = rgray;
  assign level_o     = level_q;

  // A clear may jump several Gray bits at once, so steps are only checked after ordinary cycles.
  logic [ADDR_W:0] wgray_prev, rgray_prev;
  logic            step_chk;

  always_ff @(posedge clk_i) begin
    if (step_chk) begin
      assert ($countones(wgray_prev ^ wgray) <= 1);
      assert ($countones(rgray_prev ^ rgray) <= 1);
    end
    assert (!(in_valid_i && in_ready_o && full));
    assert (!(out_ready_i && out_valid_o && empty));
    wgray_prev <= wgray;
    rgray_prev <= rgray;
    step_chk   <= ~rst_i & ~flush_i;
  end

endmodule

// File: tb/tb_gray_ptr_fifo_ctrl.sv
// tb/tb_gray_ptr_fifo_ctrl.sv - scoreboard bench for gray_ptr_fifo_ctrl
// Reference is a plain queue plus push/pop counts; Gray values derived from counts.
module tb_gray_ptr_fifo_ctrl;

  localparam int N     = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_i, flush_i, in_valid_i, out_ready_i;
  logic [N-1:0]  in_data_i;
  logic          in_ready_o, out_valid_o;
  logic [N-1:0]  out_data_o;
  logic [AW:0]   wptr_gray_o, rptr_gray_o, level_o;

  gray_ptr_fifo_ctrl #(.N(N), .ADDR_W(AW)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .wptr_gray_o (wptr_gray_o),
    .rptr_gray_o (rptr_gray_o),
    .level_o     (level_o)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  q[$];
  int          wcnt = 0;
  int          rcnt = 0;
  logic [AW:0] wg_prev, rg_prev;

  task automatic check_val(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int to_gray(input int count);
    int b;
    b = count % (2 * DEPTH);
    return b ^ (b >> 1);
  endfunction

  task automatic check_all();
    check_val("in_ready", int'(in_ready_o), int'(q.size() < DEPTH));
    check_val("out_valid", int'(out_valid_o), int'(q.size() > 0));
    check_val("level", int'(level_o), q.size());
    if (q.size() > 0) check_val("out_data", int'(out_data_o), int'(q[0]));
    check_val("wptr_gray", int'(wptr_gray_o), to_gray(wcnt));
    check_val("rptr_gray", int'(rptr_gray_o), to_gray(rcnt));
  endtask

  // Drive one cycle from the falling edge, advance the model, and check after the next falling edge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit r, input bit fl, input bit rs);
    int  sz;
    bit  do_push, do_pop;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = fl;
    rst_i       = rs;
    sz      = q.size();
    do_pop  = r && sz > 0;
    do_push = v && sz < DEPTH;
    if (rs || fl) begin
      q.delete();
      wcnt = 0;
      rcnt = 0;
    end else begin
      if (do_pop) begin
        void'(q.pop_front());
        rcnt++;
      end
      if (do_push) begin
        q.push_back(d);
        wcnt++;
      end
    end
    wg_prev = wptr_gray_o;
    rg_prev = rptr_gray_o;
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (!rs && !fl) begin
      check_val("wgray_step", $countones(wg_prev ^ wptr_gray_o) <= 1, 1);
      check_val("rgray_step", $countones(rg_prev ^ rptr_gray_o) <= 1, 1);
    end
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0; in_data_i = '0;
    @(negedge clk);
    cycle(0, 8'h00, 0, 0, 1);

    // 1: fill with 0x10..0x17
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'h10 + 8'(i), 0, 0, 0);
    check_val("t1_ready", int'(in_ready_o), 0);
    check_val("t1_level", int'(level_o), 8);
    check_val("t1_wgray", int'(wptr_gray_o), 'b1100);
    check_val("t1_data", int'(out_data_o), 'h10);

    // 2: drain in order
    for (int i = 0; i < DEPTH; i++) begin
      check_val("t2_data", int'(out_data_o), 'h10 + i);
      cycle(0, 8'h00, 1, 0, 0);
    end
    check_val("t2_valid", int'(out_valid_o), 0);
    check_val("t2_rgray", int'(rptr_gray_o), 'b1100);
    check_val("t2_eq", int'(rptr_gray_o), int'(wptr_gray_o));

    // 3: level 3 then 40 simultaneous push+pop
    for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      cycle(1, 8'($urandom), 1, 0, 0);
      check_val("t3_level", int'(level_o), 3);
    end

    // 4: full, push 0xAA with pop
    while (q.size() < DEPTH) cycle(1, 8'($urandom), 0, 0, 0);
    cycle(1, 8'hAA, 1, 0, 0);
    check_val("t4_level", int'(level_o), 7);
    check_val("t4_ready", int'(in_ready_o), 1);
    for (int i = 0; i < 7; i++) begin
      check_val("t4_no_aa", int'(out_data_o != 8'hAA), 1);
      cycle(0, 8'h00, 1, 0, 0);
    end

    // 5: level 5, flush with push 0x55
    for (int i = 0; i < 5; i++) cycle(1, 8'h30 + 8'(i), 0, 0, 0);
    cycle(1, 8'h55, 0, 1, 0);
    check_val("t5_level", int'(level_o), 0);
    check_val("t5_valid", int'(out_valid_o), 0);
    check_val("t5_wgray", int'(wptr_gray_o), 0);
    check_val("t5_rgray", int'(rptr_gray_o), 0);
    cycle(1, 8'h66, 0, 0, 0);
    check_val("t5_head", int'(out_data_o), 'h66);

    // 6: reset at level 4 with push+pop active
    for (int i = 0; i < 3; i++) cycle(1, 8'($urandom), 0, 0, 0);
    cycle(1, 8'h77, 1, 0, 1);
    check_val("t6_ready", int'(in_ready_o), 1);
    check_val("t6_valid", int'(out_valid_o), 0);
    cycle(1, 8'h88, 0, 0, 0);
    check_val("t6_head", int'(out_data_o), 'h88);

    // random valid/ready sweep with rare flush and reset
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 99) < 60, 8'($urandom), $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
